// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: requester ids, read-tag pipeline entries
// and the round-robin start helper.
package mem_arb_pkg;

    localparam int unsigned ARB_NUM_REQ = 3;
    localparam int unsigned ID_WIDTH    = (ARB_NUM_REQ > 1) ? $clog2(ARB_NUM_REQ) : 1;

    typedef logic [ID_WIDTH-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

    // Round-robin search starts one past the last granted requester.
    function automatic req_id_t rr_next(input req_id_t last, input int unsigned n);
        int unsigned nxt;
        nxt = 32'(last) + 1;
        return (nxt >= n) ? '0 : req_id_t'(nxt);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and RAM-side signals of the data-memory arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 36
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_wrEn;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_wrEn;
    logic [DATA_WIDTH-1:0]         mem_dataIn;
    logic [DATA_WIDTH-1:0]         mem_dataOut;

    modport slave (
        input  req, req_wrEn, req_lock, req_addr, req_wdata, mem_dataOut,
        output gnt, rvalid, rdata, mem_addr, mem_wrEn, mem_dataIn
    );

    modport master (
        output req, req_wrEn, req_lock, req_addr, req_wdata, mem_dataOut,
        input  gnt, rvalid, rdata, mem_addr, mem_wrEn, mem_dataIn
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Picks the first active request at or after a start index (wrapping); one-hot plus encoded id.
module rr_priority_picker
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_id_t            start,
    output logic [NUM_REQ-1:0] gnt,
    output req_id_t            id,
    output logic               found
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(start) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                id       = req_id_t'(idx);
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data RAM between requesters: round-robin or fixed priority, burst lock,
// and per-requester tagging of registered read data.
module dmem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned RD_LATENCY = 1,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input logic                clk,
    input logic                rstN,
    dmem_port_arbiter_if.slave bus
);

    req_id_t              ptr_q, ptr_d;
    req_id_t              owner_q, owner_d;
    logic                 lock_q, lock_d;
    req_id_t              start;
    logic [NUM_REQ-1:0]   pick_gnt;
    req_id_t              pick_id;
    logic                 pick_found;
    logic [NUM_REQ-1:0]   gnt;
    req_id_t              gnt_id;
    logic                 granted;
    logic                 owner_req;
    rd_tag_t              push;
    rd_tag_t              tags_q [RD_LATENCY];

    assign start     = FIXED_PRIO ? '0 : rr_next(ptr_q, NUM_REQ);
    assign owner_req = lock_q && bus.req[owner_q];

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (bus.req),
        .start (start),
        .gnt   (pick_gnt),
        .id    (pick_id),
        .found (pick_found)
    );

    // A live lock owner bypasses the picker; everyone else stalls until it lets go.
    always_comb begin
        gnt     = '0;
        gnt_id  = pick_id;
        granted = 1'b0;
        if (rstN) begin
            if (owner_req) begin
                gnt[owner_q] = 1'b1;
                gnt_id       = owner_q;
                granted      = 1'b1;
            end else begin
                gnt     = pick_gnt;
                granted = pick_found;
            end
        end
    end

    assign bus.gnt = gnt;

    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_wrEn   = 1'b0;
        bus.mem_dataIn = '0;
        if (granted) begin
            bus.mem_addr   = bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
            bus.mem_wrEn   = bus.req_wrEn[gnt_id];
            bus.mem_dataIn = bus.req_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        if (lock_q && !bus.req[owner_q]) begin
            lock_d = 1'b0;
        end
        if (granted) begin
            ptr_d   = gnt_id;
            owner_d = gnt_id;
            lock_d  = bus.req_lock[gnt_id];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            ptr_q   <= req_id_t'(NUM_REQ - 1);
            owner_q <= '0;
            lock_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        push.valid = granted && !bus.req_wrEn[gnt_id];
        push.id    = gnt_id;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            tags_q[0] <= push;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tags_q[i] <= tags_q[i-1];
            end
        end
    end

    // Gated by rstN so a read granted just before reset never reports.
    always_comb begin
        bus.rvalid = '0;
        if (rstN && tags_q[RD_LATENCY-1].valid) begin
            bus.rvalid[tags_q[RD_LATENCY-1].id] = 1'b1;
        end
    end

    assign bus.rdata = bus.mem_dataOut;

endmodule
